store_buffer: RTL and testbench

Four-entry in-order store buffer between the processor core's memory write/read ports and the data memory (or the abstract memory model in formal wrappers). Stores are queued and drained one per handshake. Loads are forwarded from the youngest matching queued store, otherwise passed to memory. A flush sequence drains the buffer before an instruction-boundary check.

---
 rtl/sbuf_pkg.sv | 18 +
 rtl/sbuf_fwd.sv | 34 +++
 rtl/store_buffer.sv | 118 +++++++++++
 tb/tb_store_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sbuf_pkg.sv
// Shared types and width helpers for the store buffer and its forwarding selector.
package sbuf_pkg;
    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_t;

    localparam int SB_DEPTH = 4;

    function automatic int sb_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int sb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sbuf_fwd.sv
// Youngest-match load forwarding over the queued stores; purely combinational.
// Later (closer to tail) matches override earlier ones as the scan walks from head.
module sbuf_fwd
    import sbuf_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic [DEPTH-1:0][AW-1:0]       ent_addr,
    input  logic [DEPTH-1:0][DW-1:0]       ent_data,
    input  logic [DEPTH-1:0]               ent_vld,
    input  logic [sb_ptr_w(DEPTH)-1:0]     head,
    input  logic [AW-1:0]                  query,
    output logic                           hit,
    output logic [DW-1:0]                  data
);
    localparam int PW = sb_ptr_w(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (ent_vld[idx] && ent_addr[idx] == query) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: stores queue and drain one per mem handshake (>=1 cycle latency),
// loads forward combinationally from the youngest match; full or flushing stalls the core.
module store_buffer
    import sbuf_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_w_en,
    input  logic [AW-1:0]           in_w_addr,
    input  logic [DW-1:0]           in_w_data,
    output logic                    in_w_ready,
    input  logic                    in_r_en,
    input  logic [AW-1:0]           in_r_addr,
    output logic [DW-1:0]           in_r_data,
    output logic                    mem_w_en,
    output logic [AW-1:0]           mem_w_addr,
    output logic [DW-1:0]           mem_w_data,
    input  logic                    mem_w_ready,
    output logic                    mem_r_en,
    output logic [AW-1:0]           mem_r_addr,
    input  logic [DW-1:0]           mem_r_data,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf
);
    localparam int PW = sb_ptr_w(DEPTH);
    localparam int CW = sb_cnt_w(DEPTH);

    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [DEPTH-1:0]         ent_vld;
    logic [PW-1:0]            head, tail, off;
    sb_state_t                state, state_nxt;
    logic                     full, push, pop, fwd_hit;
    logic [DW-1:0]            fwd_data;

    assign full       = (count == CW'(DEPTH));
    assign in_w_ready = !full && (state == SB_IDLE);
    assign push       = in_w_en && in_w_ready;
    assign mem_w_en   = (count != '0);
    assign pop        = mem_w_en && mem_w_ready;
    assign mem_w_addr = ent_addr[head];
    assign mem_w_data = ent_data[head];

    // Occupied slots are the count entries starting at head, modulo DEPTH.
    always_comb begin
        ent_vld = '0;
        off     = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off        = PW'(j) - head;
            ent_vld[j] = (CW'(off) < count);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= in_w_addr;
            ent_data[tail] <= in_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_w_en && full) ovf <= 1'b1;
        end
    end

    sbuf_fwd #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fwd (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .ent_vld  (ent_vld),
        .head     (head),
        .query    (in_r_addr),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    assign mem_r_en   = in_r_en && !fwd_hit;
    assign mem_r_addr = in_r_addr;
    assign in_r_data  = fwd_hit ? fwd_data : mem_r_data;

    always_ff @(posedge clk) begin
        if (rst) state <= SB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SB_IDLE:  if (flush_req) state_nxt = (count == '0) ? SB_DONE : SB_DRAIN;
            SB_DRAIN: if (count == '0) state_nxt = SB_DONE;
            SB_DONE:  state_nxt = SB_IDLE;
            default:  state_nxt = SB_IDLE;
        endcase
    end

    always_comb begin
        flush_done = 1'b0;
        if (state == SB_DONE) flush_done = 1'b1;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand sequences for flush/reset, random vs queue model.
module tb_store_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_w_en, in_w_ready, in_r_en, mem_w_en, mem_w_ready, mem_r_en;
    logic [7:0] in_w_addr, in_w_data, in_r_addr, in_r_data;
    logic [7:0] mem_w_addr, mem_w_data, mem_r_addr, mem_r_data;
    logic       flush_req, flush_done, ovf;
    logic [2:0] count;

    store_buffer #(.AW(8), .DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_w_en(in_w_en), .in_w_addr(in_w_addr), .in_w_data(in_w_data), .in_w_ready(in_w_ready),
        .in_r_en(in_r_en), .in_r_addr(in_r_addr), .in_r_data(in_r_data),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_ready(mem_w_ready),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .flush_req(flush_req), .flush_done(flush_done), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w_en, w_addr, w_data, r_en, r_addr, mrd, mwr, flush;
        int cnt, wrdy, mwen, mwa, mwd, rdata, mren, fdone, ovf;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input vec_t r);
        tbl.push_back(r);
    endtask

    task automatic idle_inputs();
        in_w_en = 0; in_w_addr = 0; in_w_data = 0;
        in_r_en = 0; in_r_addr = 0; mem_r_data = 0;
        mem_w_ready = 0; flush_req = 0;
    endtask

    task automatic push_store(input logic [7:0] a, input logic [7:0] d);
        in_w_en = 1; in_w_addr = a; in_w_data = d;
    endtask

    initial begin
        int   pulses;
        int   sz;
        bit   m_ovf, m_flushing, m_done, hit, exp_wrdy, r_rst;
        logic [7:0] fwd;

        // w_en,w_addr,w_data, r_en,r_addr,mrd, mwr,flush, cnt,wrdy,mwen,mwa,mwd, rdata,mren,fdone,ovf
        add('{0,0,0,       1,'h55,'h33, 0,0, 0,1,0,0,0,         'h33,1,0,0});
        add('{1,'h10,'hAA, 0,0,0,       0,0, 0,1,0,0,0,         0,0,0,0});
        add('{0,0,0,       0,0,0,       0,0, 1,1,1,'h10,'hAA,   0,0,0,0});
        add('{0,0,0,       0,0,0,       1,0, 1,1,1,'h10,'hAA,   0,0,0,0});
        add('{0,0,0,       0,0,0,       0,0, 0,1,0,0,0,         0,0,0,0});
        add('{1,'h20,'h01, 0,0,0,       0,0, 0,1,0,0,0,         0,0,0,0});
        add('{1,'h20,'h02, 0,0,0,       0,0, 1,1,1,'h20,'h01,   0,0,0,0});
        add('{0,0,0,       1,'h20,'h77, 0,0, 2,1,1,'h20,'h01,   'h02,0,0,0});
        add('{0,0,0,       1,'h30,'h5C, 0,0, 2,1,1,'h20,'h01,   'h5C,1,0,0});
        add('{0,0,0,       0,0,0,       1,0, 2,1,1,'h20,'h01,   0,0,0,0});
        add('{0,0,0,       0,0,0,       1,0, 1,1,1,'h20,'h02,   0,0,0,0});
        add('{0,0,0,       0,0,0,       0,0, 0,1,0,0,0,         0,0,0,0});
        add('{1,'h41,'hB1, 0,0,0,       0,0, 0,1,0,0,0,         0,0,0,0});
        add('{1,'h42,'hB2, 0,0,0,       0,0, 1,1,1,'h41,'hB1,   0,0,0,0});
        add('{1,'h43,'hB3, 0,0,0,       0,0, 2,1,1,'h41,'hB1,   0,0,0,0});
        add('{1,'h44,'hB4, 0,0,0,       0,0, 3,1,1,'h41,'hB1,   0,0,0,0});
        add('{1,'h45,'hB5, 0,0,0,       0,0, 4,0,1,'h41,'hB1,   0,0,0,0});
        add('{1,'h4A,'hBA, 0,0,0,       0,0, 4,0,1,'h41,'hB1,   0,0,0,1});
        add('{0,0,0,       1,'h44,'h12, 1,0, 4,0,1,'h41,'hB1,   'hB4,0,0,1});
        add('{1,'h46,'hB6, 1,'h42,'h11, 1,0, 3,1,1,'h42,'hB2,   'hB2,0,0,1});
        add('{1,'h47,'hB7, 0,0,0,       1,0, 3,1,1,'h43,'hB3,   0,0,0,1});
        add('{1,'h48,'hB8, 0,0,0,       1,0, 3,1,1,'h44,'hB4,   0,0,0,1});
        add('{1,'h49,'hB9, 0,0,0,       1,0, 3,1,1,'h46,'hB6,   0,0,0,1});
        add('{0,0,0,       0,0,0,       1,0, 3,1,1,'h47,'hB7,   0,0,0,1});
        add('{0,0,0,       0,0,0,       1,0, 2,1,1,'h48,'hB8,   0,0,0,1});
        add('{0,0,0,       0,0,0,       1,0, 1,1,1,'h49,'hB9,   0,0,0,1});
        add('{0,0,0,       0,0,0,       0,0, 0,1,0,0,0,         0,0,0,1});
        add('{1,'h50,'hD0, 1,'h50,'h99, 0,0, 0,1,0,0,0,         'h99,1,0,1});
        add('{0,0,0,       1,'h50,'h98, 1,0, 1,1,1,'h50,'hD0,   'hD0,0,0,1});
        add('{0,0,0,       0,0,0,       0,0, 0,1,0,0,0,         0,0,0,1});
        add('{0,0,0,       0,0,0,       0,1, 0,1,0,0,0,         0,0,0,1});
        add('{0,0,0,       0,0,0,       0,0, 0,0,0,0,0,         0,0,1,1});
        add('{0,0,0,       0,0,0,       0,0, 0,1,0,0,0,         0,0,0,1});

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            in_w_en = 1'(tbl[i].w_en); in_w_addr = 8'(tbl[i].w_addr); in_w_data = 8'(tbl[i].w_data);
            in_r_en = 1'(tbl[i].r_en); in_r_addr = 8'(tbl[i].r_addr); mem_r_data = 8'(tbl[i].mrd);
            mem_w_ready = 1'(tbl[i].mwr); flush_req = 1'(tbl[i].flush);
            #1;
            chk($sformatf("row%0d count", i), 32'(count), tbl[i].cnt);
            chk($sformatf("row%0d in_w_ready", i), 32'(in_w_ready), tbl[i].wrdy);
            chk($sformatf("row%0d mem_w_en", i), 32'(mem_w_en), tbl[i].mwen);
            if (tbl[i].mwen != 0) begin
                chk($sformatf("row%0d mem_w_addr", i), 32'(mem_w_addr), tbl[i].mwa);
                chk($sformatf("row%0d mem_w_data", i), 32'(mem_w_data), tbl[i].mwd);
            end
            chk($sformatf("row%0d in_r_data", i), 32'(in_r_data), tbl[i].rdata);
            chk($sformatf("row%0d mem_r_en", i), 32'(mem_r_en), tbl[i].mren);
            chk($sformatf("row%0d flush_done", i), 32'(flush_done), tbl[i].fdone);
            chk($sformatf("row%0d ovf", i), 32'(ovf), tbl[i].ovf);
            tick();
        end

        // Flush with three queued entries; a store is held pending throughout the drain.
        idle_inputs();
        push_store(8'h61, 8'hC1); tick();
        push_store(8'h62, 8'hC2); tick();
        push_store(8'h63, 8'hC3); tick();
        in_w_en = 0; flush_req = 1; mem_w_ready = 1;
        #1;
        chk("flush start count", 32'(count), 3);
        tick();
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            flush_req = 0;
            push_store(8'h64, 8'hC4);
            #1;
            chk($sformatf("flush k%0d flush_done", k), 32'(flush_done), (k == 4) ? 1 : 0);
            chk($sformatf("flush k%0d in_w_ready", k), 32'(in_w_ready), (k >= 5) ? 1 : 0);
            chk($sformatf("flush k%0d count", k), 32'(count), (k < 3) ? 3 - k : 0);
            pulses += int'(flush_done);
            tick();
        end
        chk("flush pulse total", 32'(pulses), 1);
        in_w_en = 0; mem_w_ready = 0;
        #1;
        chk("stalled store count", 32'(count), 1);
        chk("stalled store addr", 32'(mem_w_addr), 'h64);
        chk("stalled store data", 32'(mem_w_data), 'hC4);
        tick();
        mem_w_ready = 1; tick();
        mem_w_ready = 0;

        // Reset in the middle of a drain discards the remaining entry and the sticky ovf.
        push_store(8'h71, 8'hE1); tick();
        push_store(8'h72, 8'hE2); tick();
        in_w_en = 0; mem_w_ready = 1; tick();
        rst = 1; tick();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rst k%0d count", k), 32'(count), 0);
            chk($sformatf("rst k%0d mem_w_en", k), 32'(mem_w_en), 0);
            chk($sformatf("rst k%0d ovf", k), 32'(ovf), 0);
            chk($sformatf("rst k%0d in_w_ready", k), 32'(in_w_ready), 1);
            tick();
        end
        flush_req = 1; tick();
        flush_req = 0;
        #1;
        chk("rst idle flush_done", 32'(flush_done), 1);
        tick();

        // Random traffic against a queue model.
        idle_inputs();
        rst = 1; tick(); rst = 0;
        m_ovf = 0; m_flushing = 0; m_done = 0;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            r_rst       = ($urandom_range(0, 199) == 0);
            rst         = r_rst;
            in_w_en     = 1'($urandom_range(0, 1));
            in_w_addr   = 8'h80 + 8'($urandom_range(0, 5));
            in_w_data   = 8'($urandom);
            in_r_en     = 1'($urandom_range(0, 1));
            in_r_addr   = 8'h80 + 8'($urandom_range(0, 5));
            mem_r_data  = 8'($urandom);
            mem_w_ready = ($urandom_range(0, 9) < 4);
            flush_req   = ($urandom_range(0, 19) == 0);
            #1;
            sz = mq.size();
            hit = 0; fwd = 0;
            for (int i = sz - 1; i >= 0; i--) begin
                if (mq[i].a == in_r_addr) begin
                    hit = 1; fwd = mq[i].d;
                    break;
                end
            end
            exp_wrdy = (sz < 4) && !m_flushing && !m_done;
            chk($sformatf("rnd%0d count", c), 32'(count), sz);
            chk($sformatf("rnd%0d in_w_ready", c), 32'(in_w_ready), 32'(exp_wrdy));
            chk($sformatf("rnd%0d mem_w_en", c), 32'(mem_w_en), (sz != 0) ? 1 : 0);
            if (sz != 0) begin
                chk($sformatf("rnd%0d mem_w_addr", c), 32'(mem_w_addr), 32'(mq[0].a));
                chk($sformatf("rnd%0d mem_w_data", c), 32'(mem_w_data), 32'(mq[0].d));
            end
            chk($sformatf("rnd%0d in_r_data", c), 32'(in_r_data), hit ? 32'(fwd) : 32'(mem_r_data));
            chk($sformatf("rnd%0d mem_r_en", c), 32'(mem_r_en), 32'(in_r_en && !hit));
            chk($sformatf("rnd%0d mem_r_addr", c), 32'(mem_r_addr), 32'(in_r_addr));
            chk($sformatf("rnd%0d flush_done", c), 32'(flush_done), 32'(m_done));
            chk($sformatf("rnd%0d ovf", c), 32'(ovf), 32'(m_ovf));
            if (r_rst) begin
                mq.delete();
                m_ovf = 0; m_flushing = 0; m_done = 0;
            end else begin
                if (in_w_en && sz == 4) m_ovf = 1;
                if (sz != 0 && mem_w_ready) void'(mq.pop_front());
                if (in_w_en && exp_wrdy) mq.push_back('{in_w_addr, in_w_data});
                if (m_done) m_done = 0;
                else if (m_flushing) begin
                    if (sz == 0) begin m_flushing = 0; m_done = 1; end
                end else if (flush_req) begin
                    if (sz == 0) m_done = 1;
                    else m_flushing = 1;
                end
            end
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
